// File: rtl/oam_dma_controller.sv
// OAM DMA controller: on a CPU write to the DMA trigger register, stalls the
// CPU and copies one 256-byte page from the system bus into the PPU OAM data
// port. Each byte takes a read cycle and then a write cycle. Reads always fall
// on get (even) CPU cycles.
module oam_dma_controller #(
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic        clkMaster,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic        cpu_put,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] bus_addr,
    output logic        bus_wr,
    output logic [7:0]  bus_wdata,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [7:0] offset;
    logic [7:0] data;

    // Handshake with the CPU: cpu_rdy low means the CPU must hold its current
    // cycle. The DMA owns the bus (dma_active) only in READ and WRITE. Every
    // register below advances only on cpu_ce, once per CPU cycle.

    // Transfer sequencer: trigger detect, halt until a read cycle, get/put
    // alignment, then 256 read/write pairs that stay inside the latched page.
    always_ff @(posedge clkMaster or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            page   <= 8'h00;
            offset <= 8'h00;
            data   <= 8'h00;
        end else if (cpu_ce) begin
            case (state)
                IDLE: begin
                    if (!cpu_rw && cpu_addr == DMA_REG_ADDR) begin
                        page   <= cpu_wdata;
                        offset <= 8'h00;
                        state  <= HALT;
                    end
                end
                HALT: begin
                    // The CPU cannot be stalled on a write cycle, so wait for a read.
                    if (cpu_rw) begin
                        state <= cpu_put ? READ : ALIGN;
                    end
                end
                ALIGN: begin
                    state <= READ;
                end
                READ: begin
                    data  <= bus_rdata;
                    state <= WRITE;
                end
                WRITE: begin
                    if (offset == 8'hFF) begin
                        state <= IDLE;
                    end else begin
                        // Offset wraps within 8 bits; page never increments.
                        offset <= offset + 8'h01;
                        state  <= READ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus and CPU outputs decoded from registered state only, so no input
    // reaches an output without passing through a flop.
    always_comb begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        bus_addr   = 16'h0000;
        bus_wr     = 1'b0;
        bus_wdata  = 8'h00;
        case (state)
            IDLE: begin
                cpu_rdy = 1'b1;
            end
            HALT, ALIGN: begin
                cpu_rdy = 1'b0;
            end
            READ: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                bus_addr   = {page, offset};
            end
            WRITE: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                bus_addr   = OAMDATA_ADDR;
                bus_wr     = 1'b1;
                bus_wdata  = data;
            end
            default: begin
                cpu_rdy = 1'b1;
            end
        endcase
    end

    assign state_dbg = state;

endmodule
